// File: rtl/mouse_pkt_assembler_pkg.sv
// mouse_pkt_assembler_pkg: shared command bytes, FSM states and helpers for the PS/2 mouse packet assembler
package mouse_pkt_assembler_pkg;
  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  localparam logic [7:0] ACK = 8'hFA;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WTX, S_WACK, S_B1, S_B2, S_B3} state_t;
  function automatic logic timed_state(input state_t s);
    return s inside {S_WTX, S_WACK, S_B2, S_B3};
  endfunction
endpackage

// File: rtl/mouse_pkt_assembler_timer.sv
// ps2_timeout_timer: cycle counter that pulses expired on its last count while enabled
module ps2_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  logic [W-1:0] cnt;
  // count while enabled; any clear (state change or bus activity) restarts the window
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  assign expired = enable && cnt == LAST;
endmodule

// File: rtl/mouse_pkt_assembler.sv
// mouse_pkt_assembler: enables PS/2 mouse reporting, then assembles 3-byte movement packets
module mouse_pkt_assembler
  import mouse_pkt_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic [1:0] ovf,
  output logic       m_done_tick,
  output logic       init_done,
  output logic       init_err
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, state_nx;
  logic tick, expired, timeout, retry_inc, is_ack;
  logic [RW-1:0] retry;
  logic [7:0] byte1, byte2;
  assign din = CMD_EN_REPORT;
  assign wr_ps2 = state == S_INIT;
  assign tick = rx_done_tick | tx_done_tick;
  assign timeout = expired & ~tick;
  assign is_ack = rx_done_tick && rx_data == ACK;
  assign retry_inc = timeout && (state == S_WTX || state == S_WACK);
  ps2_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(tick | (state_nx != state)),
    .enable(timed_state(state)),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_nx;
  // next state; a byte or tx completion in the same cycle as expiry wins over the timeout
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_INIT;
      S_INIT: state_nx = S_WTX;
      S_WTX:  state_nx = tx_done_tick ? S_WACK : timeout ? S_INIT : S_WTX;
      S_WACK: state_nx = is_ack ? S_B1 : timeout ? S_INIT : S_WACK;
      S_B1:   state_nx = (rx_done_tick && rx_data[3]) ? S_B2 : S_B1;
      S_B2:   state_nx = rx_done_tick ? S_B3 : timeout ? S_B1 : S_B2;
      S_B3:   state_nx = (rx_done_tick || timeout) ? S_B1 : S_B3;
      default: state_nx = S_IDLE;
    endcase
  end
  // init handshake status: saturating retry count, sticky error, ACK-level done
  always_ff @(posedge clk)
    if (reset) begin
      retry <= '0;
      init_err <= 1'b0;
      init_done <= 1'b0;
    end else begin
      if (retry_inc && retry != RW'(MAX_RETRY)) retry <= retry + RW'(1);
      if (retry_inc && retry >= RW'(MAX_RETRY - 1)) init_err <= 1'b1;
      if (state == S_WACK && is_ack) init_done <= 1'b1;
    end
  // packet capture; outputs update together with the byte-3 edge and hold until the next packet
  always_ff @(posedge clk)
    if (reset) begin
      byte1 <= '0;
      byte2 <= '0;
      xm <= '0;
      ym <= '0;
      btnm <= '0;
      ovf <= '0;
      m_done_tick <= 1'b0;
    end else begin
      m_done_tick <= state == S_B3 && rx_done_tick;
      if (state == S_B1 && rx_done_tick && rx_data[3]) byte1 <= rx_data;
      if (state == S_B2 && rx_done_tick) byte2 <= rx_data;
      if (state == S_B3 && rx_done_tick) begin
        xm <= {byte1[4], byte2};
        ym <= {byte1[5], rx_data};
        btnm <= byte1[2:0];
        ovf <= byte1[7:6];
      end
    end
endmodule

// File: tb/tb_mouse_pkt_assembler.sv
// tb_mouse_pkt_assembler: randomized scoreboard bench with a byte-list packet model
module tb_mouse_pkt_assembler;
  localparam int TO = 100;
  localparam int MR = 3;
  logic clk = 0, reset = 1, rx_done_tick = 0, tx_done_tick = 0;
  logic [7:0] rx_data = 0;
  logic wr_ps2, m_done_tick, init_done, init_err;
  logic [7:0] din;
  logic [8:0] xm, ym;
  logic [2:0] btnm;
  logic [1:0] ovf;
  int total = 0, bad = 0, cyc = 0, last_e = 0;
  typedef struct {
    logic [8:0] xm, ym;
    logic [2:0] btn;
    logic [1:0] ovf;
    int at_cyc;
  } pkt_t;
  pkt_t sb[$];
  logic [7:0] mp[$];

  mouse_pkt_assembler #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .din(din), .xm(xm), .ym(ym),
    .btnm(btnm), .ovf(ovf), .m_done_tick(m_done_tick), .init_done(init_done),
    .init_err(init_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // reference: a packet is three bytes, the first having bit3 set, with no gap longer than TO
  task automatic model_byte(input logic [7:0] b, input int e);
    pkt_t p;
    int x, y;
    if (mp.size() > 0 && e - last_e > TO) mp.delete();
    last_e = e;
    if (mp.size() == 0 && !b[3]) return;
    mp.push_back(b);
    if (mp.size() == 3) begin
      x = int'(mp[1]) - ((mp[0] / 16) % 2 == 1 ? 256 : 0);
      y = int'(mp[2]) - ((mp[0] / 32) % 2 == 1 ? 256 : 0);
      p.xm = 9'(x);
      p.ym = 9'(y);
      p.btn = 3'(mp[0] % 8);
      p.ovf = 2'(mp[0] / 64);
      p.at_cyc = e;
      sb.push_back(p);
      mp.delete();
    end
  endtask

  task automatic send_raw(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1;
    @(negedge clk);
    rx_done_tick = 0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    model_byte(b, cyc + 1);
    send_raw(b);
  endtask

  task automatic pulse_tx();
    tx_done_tick = 1;
    @(negedge clk);
    tx_done_tick = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input int lim, output int n);
    n = 0;
    while (!wr_ps2 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ps2_seen", int'(wr_ps2), 1);
  endtask

  task automatic chk_pkt(input string nm, input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    chk({nm, "_tick"}, int'(m_done_tick), 1);
    chk({nm, "_xm"}, int'(xm), int'(x));
    chk({nm, "_ym"}, int'(ym), int'(y));
    chk({nm, "_btn"}, int'(btnm), int'(b));
    chk({nm, "_ovf"}, int'(ovf), 0);
  endtask

  // monitor: every command strobe carries F4, every packet tick matches the oldest expectation
  always @(negedge clk) begin
    pkt_t p;
    if (wr_ps2) chk("din", int'(din), 8'hF4);
    if (m_done_tick) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick actual=1 required=0 cyc=%0d", cyc);
      end else begin
        p = sb.pop_front();
        chk("sb_xm", int'(xm), int'(p.xm));
        chk("sb_ym", int'(ym), int'(p.ym));
        chk("sb_btn", int'(btnm), int'(p.btn));
        chk("sb_ovf", int'(ovf), int'(p.ovf));
        chk("sb_tick_cycle", cyc, p.at_cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    idle(4);
    chk("rst_xm", int'(xm), 0);
    chk("rst_ym", int'(ym), 0);
    chk("rst_btn_ovf", int'({btnm, ovf}), 0);
    chk("rst_flags", int'({m_done_tick, wr_ps2, init_done, init_err}), 0);
    reset = 0;
    wait_wr(10, n);
    chk("din_init", int'(din), 8'hF4);
    @(negedge clk);
    chk("wr_width", int'(wr_ps2), 0);
    idle(3);
    pulse_tx();
    idle(3);
    send_raw(8'h55);
    chk("init_not_done", int'(init_done), 0);
    send_raw(8'hFA);
    chk("init_done", int'(init_done), 1);
    chk("init_err_clear", int'(init_err), 0);
    idle(2);
    send_rx(8'h29); send_rx(8'h10); send_rx(8'hF0);
    chk_pkt("pkt1", 9'h010, 9'h1F0, 3'b001);
    idle(3);
    send_rx(8'h00); send_rx(8'h29); send_rx(8'h10); send_rx(8'hF0);
    chk_pkt("resync", 9'h010, 9'h1F0, 3'b001);
    idle(3);
    send_rx(8'h29); send_rx(8'h10);
    idle(150);
    send_rx(8'h08); send_rx(8'h05); send_rx(8'h03);
    chk_pkt("tmo", 9'h005, 9'h003, 3'b000);
    for (int i = 0; i < 150; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 2) == 0) b[3] = 1'b1;
      send_rx(b);
      idle($urandom_range(0, 24) == 0 ? 150 + $urandom_range(0, 30) : $urandom_range(0, 4));
    end
    idle(3);
    mp.delete();
    send_rx(8'h29); send_rx(8'h10);
    idle(2);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_xy", int'({xm, ym}), 0);
    chk("mid_rst_out", int'({btnm, ovf, m_done_tick, init_done}), 0);
    idle(2);
    mp.delete();
    reset = 0;
    wait_wr(10, n);
    for (int k = 1; k <= 3; k++) begin
      chk("err_before", int'(init_err), 0);
      @(negedge clk);
      wait_wr(300, n);
      chk("retry_gap_ok", int'(n + 1 >= 100 && n + 1 <= 102), 1);
    end
    chk("init_err_set", int'(init_err), 1);
    idle(2);
    pulse_tx();
    idle(2);
    send_raw(8'hFA);
    chk("reinit_done", int'(init_done), 1);
    chk("err_sticky", int'(init_err), 1);
    idle(2);
    send_rx(8'h1B); send_rx(8'h7F); send_rx(8'h80);
    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
